// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

  // Converter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A working digit at or above this value is corrected before the next shift.
  localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
  // The correction: after doubling, +3 becomes +6 and pushes the digit past 9 into a carry.
  localparam logic [3:0] ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit's add-3 correction for the double-dabble step.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Input never exceeds 9, so the 4-bit sum cannot wrap.
  always_comb begin
    digit_o = (digit_i >= ADJ_THRESHOLD) ? digit_i + ADJ_ADD : digit_i;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// The result register only updates when a conversion completes, so downstream
// 7-segment decoders never see intermediate values.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 8,
  parameter int unsigned DIGITS    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BcdW-1:0]      work_q, work_d;
  logic [BcdW-1:0]      work_adj;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  // Per-digit add-3 correction, applied to all working digits in parallel.
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (work_q[4*k +: 4]),
      .digit_o (work_adj[4*k +: 4])
    );
  end

  // Next-state logic for the FSM, datapath and result registers.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          bin_d    = bin_in;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = CntW'(BIN_WIDTH);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d   = {work_adj[BcdW-2:0], bin_q[BIN_WIDTH-1]};
        bin_d    = bin_q << 1;
        // A bit leaving the top digit means the value does not fit in DIGITS digits.
        sticky_d = sticky_q | work_adj[BcdW-1];
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // done is registered alongside the result so both appear on the same cycle.
        done_d  = 1'b1;
        bcd_d   = work_q;
        ovf_d   = sticky_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      bcd_q    <= bcd_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Output mapping.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = done_q;
    bcd_out  = bcd_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (3-digit and 2-digit builds).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [7:0]  bin_in, bin2;
  logic        busy, done, ovf;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd;
  logic [7:0]  bcd2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd),
    .overflow (ovf)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .bin_in   (bin2),
    .busy     (busy2),
    .done     (done2),
    .bcd_out  (bcd2),
    .overflow (ovf2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] dec3(input int v);
    dec3 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Launch one conversion from the current negedge and wait (bounded) for done.
  task automatic run_conv(input bit sel, input logic [7:0] v, output logic [11:0] res,
                          output logic res_ovf, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    res = '0;
    res_ovf = 1'b0;
    if (!sel) begin
      start = 1'b1; bin_in = v;
    end else begin
      start2 = 1'b1; bin2 = v;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0; start2 = 1'b0;
      bin_in = ~v;  bin2 = ~v;
      if (sel ? busy2 : busy) busy_cnt++;
      if (sel ? done2 : done) begin
        lat = k;
        res = sel ? {4'h0, bcd2} : bcd;
        res_ovf = sel ? ovf2 : ovf;
        break;
      end
    end
  endtask

  task automatic do_vec(input bit sel, input logic [7:0] v, input logic [11:0] exp_bcd,
                        input logic exp_ovf, input string tag);
    logic [11:0] res;
    logic        r_ovf;
    int          lat, bc;
    run_conv(sel, v, res, r_ovf, lat, bc);
    check_eq({tag, "_latency"}, lat, 10);
    check_eq({tag, "_busy_cycles"}, bc, 9);
    check_eq({tag, "_bcd"}, {20'h0, res}, {20'h0, exp_bcd});
    check_eq({tag, "_ovf"}, {31'h0, r_ovf}, {31'h0, exp_ovf});
  endtask

  initial begin
    int          lat, n_done, n_busy;
    logic        held_ok;

    rst_n = 1'b0;
    start = 1'b0; start2 = 1'b0;
    bin_in = '0;  bin2 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'h0, busy}, 0);
    check_eq("rst_done", {31'h0, done}, 0);
    check_eq("rst_bcd", {20'h0, bcd}, 0);
    check_eq("rst_ovf", {31'h0, ovf}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values; each launches on the done cycle of the previous one.
    do_vec(1'b0, 8'd0,   12'h000, 1'b0, "v0");
    do_vec(1'b0, 8'd255, 12'h255, 1'b0, "v255");
    do_vec(1'b0, 8'd99,  12'h099, 1'b0, "v99");
    do_vec(1'b0, 8'd100, 12'h100, 1'b0, "v100");
    do_vec(1'b0, 8'd1,   12'h001, 1'b0, "v1");
    do_vec(1'b0, 8'd128, 12'h128, 1'b0, "v128");

    // Back-to-back exhaustive sweep.
    for (int v = 0; v < 256; v++) begin
      do_vec(1'b0, 8'(v), dec3(v), 1'b0, $sformatf("sweep%0d", v));
    end
    @(negedge clk);
    check_eq("sweep_done_single", {31'h0, done}, 0);
    check_eq("sweep_idle", {31'h0, busy}, 0);

    // Two-digit build: overflow wraps mod 100 and the sticky flag clears per start.
    do_vec(1'b1, 8'd200, 12'h000, 1'b1, "d2_200");
    do_vec(1'b1, 8'd99,  12'h099, 1'b0, "d2_99");
    do_vec(1'b1, 8'd150, 12'h050, 1'b1, "d2_150");
    @(negedge clk);

    // start during SHIFT and during DONE must be ignored; old result held until done.
    lat = 0;
    held_ok = 1'b1;
    start = 1'b1; bin_in = 8'd42;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1)  start = 1'b0;
      if (k == 3)  begin start = 1'b1; bin_in = 8'd7; end
      if (k == 5)  start = 1'b0;
      if (k == 9)  begin start = 1'b1; bin_in = 8'd7; end
      if (k == 10) start = 1'b0;
      if (done) begin
        lat = k;
        check_eq("ign_bcd", {20'h0, bcd}, 32'h042);
        break;
      end
      if (bcd !== 12'h255) held_ok = 1'b0;
    end
    check_eq("ign_latency", lat, 10);
    check_eq("ign_held", {31'h0, held_ok}, 1);
    n_done = 0;
    n_busy = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check_eq("ign_no_extra_done", n_done, 0);
    check_eq("ign_not_queued", n_busy, 0);

    // Asynchronous reset mid-SHIFT aborts without a done pulse.
    start = 1'b1; bin_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {31'h0, busy}, 0);
    check_eq("arst_bcd", {20'h0, bcd}, 0);
    check_eq("arst_ovf", {31'h0, ovf}, 0);
    check_eq("arst_done", {31'h0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("arst_no_done", n_done, 0);
    do_vec(1'b0, 8'd173, 12'h173, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
